fp_div48_seq: RTL and testbench
===============================

Name: fp_div48_seq

Overview:
- Request sequencer that sits directly upstream of the 48-bit floating-point divider (fpDivide48nr), issuing queued operations to it.
- Accepts tagged divide requests over a valid/ready interface and buffers them in a small FIFO.
- Launches one divide at a time with a single-cycle load pulse, and holds the divider operands stable for the whole operation.
- Masks the divider's stale done, captures the rounded result, and returns it with its tag over a valid/ready result interface; a watchdog returns a qNaN if the divider never completes.

Parameters:
- DEPTH, 4, request FIFO entries (power of two, ≥2).
- TAGW, 4, request/result tag width.
- DONE_MASK, 4, cycles after the load pulse during which div_done is ignored (covers done-drop latency plus the output delay stages).
- TIMEOUT, 255, maximum WAIT cycles before the watchdog fires (≤ 2^10-1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept.
- req_a  in  48  dividend (FP48).
- req_b  in  48  divisor (FP48).
- req_rm  in  3  rounding mode.
- req_tag  in  TAGW  request tag.
- div_rst  out  1  synchronous reset to the divider.
- div_ld  out  1  one-cycle load pulse.
- div_a  out  48  operand a to the divider.
- div_b  out  48  operand b to the divider.
- div_rm  out  3  rounding mode to the divider.
- div_o  in  48  divider result.
- div_done  in  1  divider done.
- div_inf  in  1  divider infinity flag.
- div_ovf  in  1  divider overflow flag.
- div_unf  in  1  divider underflow flag.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts.
- res_o  out  48  result value.
- res_tag  out  TAGW  result tag.
- res_flags  out  4  {timeout, inf, overflow, underflow}.
- busy  out  1  FIFO non-empty, or state≠IDLE, or res_valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO emptied; state=IDLE; counters cleared.
  - res_valid=0, res_o=0, res_tag=0, res_flags=0.
  - div_ld=0, div_a/div_b/div_rm=0.
  - div_rst=1; div_rst stays 1 through the first clock edge after release, then 0.
  - A reset mid-operation discards the in-flight divide and all queued requests; no result is emitted for them.
- FIFO:
  - req_ready = !full (no full-bypass).
  - Push on req_valid&req_ready.
  - Pop occurs in IDLE on a launch; a push and a pop in the same cycle are both honoured.
  - Pointers wrap modulo DEPTH; a full/empty extra bit disambiguates.
- State machine (all outputs registered):
  - IDLE: when the FIFO is non-empty and res_valid=0, pop the head, latch it into div_a/div_b/div_rm and a tag register, go to LAUNCH. Otherwise stay.
  - LAUNCH: div_ld=1 for exactly this cycle; clear the counter; go to MASK.
  - MASK: div_done ignored; count to DONE_MASK-1, then go to WAIT.
  - WAIT: the counter increments each cycle.
    - If div_done=1: capture res_o=div_o, res_flags={0,div_inf,div_ovf,div_unf}, res_tag=tag register, set res_valid, go to IDLE.
    - Else if the counter reaches TIMEOUT: res_o=48'h7FF8_0000_0000, res_flags=4'b1000, set res_valid, pulse div_rst for 1 cycle, go to IDLE.
    - div_done takes priority over the timeout in the same cycle.
- div_a/div_b/div_rm change only on a launch; they are stable from LAUNCH through capture.
- Result slot:
  - res_valid clears on res_valid&res_ready.
  - res_o/res_tag/res_flags hold while res_valid=1 and res_ready=0.
  - A launch requires res_valid=0, so back-pressure stalls issue and never drops a result.
- Latency: request accepted into an empty FIFO at cycle t → div_ld at t+2 → result visible no earlier than t+3+DONE_MASK.
- Results return in request order (single outstanding divide).

Test Plan:
- Single request: a=48'h4018_0000_0000 (6.0), b=48'h4000_0000_0000 (2.0), rm=0, tag=5, res_ready=1 → one div_ld pulse; divider model returns 48'h4008_0000_0000 (3.0) → res_valid with res_o=3.0, res_tag=5, res_flags=0.
- Back-to-back: push 6 requests with tags 0..5 while the divider is busy → req_ready drops after the 4th queued entry; results emerge with tags 0..5 in order, exactly one div_ld per request.
- Stale done: divider model holds div_done=1 for DONE_MASK cycles after ld, then 0 for 20 cycles, then 1 → no capture until the final rise; the result matches the model value.
- Back-pressure: res_ready=0 for 50 cycles with 2 requests queued → the first result is held stable, no second div_ld, busy=1; raise res_ready → the second launch occurs within 2 cycles.
- Timeout: div_done stuck at 0 → after TIMEOUT WAIT cycles, res_o=48'h7FF8_0000_0000, res_flags=4'b1000, one-cycle div_rst pulse; the next queued request proceeds normally.
- Reset mid-divide: assert rst_n=0 during WAIT with 3 requests queued → outputs are immediately at reset values, req_ready=1 after release, no stale result appears, and div_rst is high until the first clock edge after release.

Source files
------------

// File: rtl/fp_div48_seq_if.sv
// Request and result channels between a client and the fp_div48_seq sequencer.
interface fp_div48_seq_if #(
  parameter int unsigned TAGW = 4
);
  logic            req_valid;
  logic            req_ready;
  logic [47:0]     req_a;
  logic [47:0]     req_b;
  logic [2:0]      req_rm;
  logic [TAGW-1:0] req_tag;
  logic            res_valid;
  logic            res_ready;
  logic [47:0]     res_o;
  logic [TAGW-1:0] res_tag;
  logic [3:0]      res_flags;

  // Client side: issues requests, consumes results.
  modport master (
    output req_valid, req_a, req_b, req_rm, req_tag, res_ready,
    input  req_ready, res_valid, res_o, res_tag, res_flags
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_a, req_b, req_rm, req_tag, res_ready,
    output req_ready, res_valid, res_o, res_tag, res_flags
  );
endinterface

// File: rtl/fp_div48_seq.sv
// Request sequencer for the 48-bit FP divider: queues tagged requests, launches one divide
// at a time, masks stale done, returns results in order, and recovers from a hung divider.
module fp_div48_seq #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TAGW      = 4,
  parameter int unsigned DONE_MASK = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_div48_seq_if.slave bus,
  output logic          div_rst,
  output logic          div_ld,
  output logic [47:0]   div_a,
  output logic [47:0]   div_b,
  output logic [2:0]    div_rm,
  input  logic [47:0]   div_o,
  input  logic          div_done,
  input  logic          div_inf,
  input  logic          div_ovf,
  input  logic          div_unf,
  output logic          busy
);
  localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [9:0]  MaskLast    = 10'(DONE_MASK - 1);
  localparam logic [9:0]  TimeoutLast = 10'(TIMEOUT - 1);
  localparam logic [47:0] QNaN        = 48'h7FF8_0000_0000;

  typedef enum logic [1:0] {StIdle, StLaunch, StMask, StWait} state_e;

  logic [47:0]     r_mem_a   [DEPTH];
  logic [47:0]     r_mem_b   [DEPTH];
  logic [2:0]      r_mem_rm  [DEPTH];
  logic [TAGW-1:0] r_mem_tag [DEPTH];

  logic [AW:0]     r_wptr, r_rptr;
  logic [AW-1:0]   w_wa, w_ra;
  logic            w_empty, w_full, w_push, w_pop;

  state_e          r_state, w_state_d;
  logic [9:0]      r_cnt, w_cnt_d;
  logic            r_div_rst, w_div_rst_d;
  logic            r_div_ld, w_div_ld_d;
  logic [47:0]     r_div_a, w_div_a_d;
  logic [47:0]     r_div_b, w_div_b_d;
  logic [2:0]      r_div_rm, w_div_rm_d;
  logic [TAGW-1:0] r_tag, w_tag_d;
  logic            r_res_valid, w_res_valid_d;
  logic [47:0]     r_res_o, w_res_o_d;
  logic [TAGW-1:0] r_res_tag, w_res_tag_d;
  logic [3:0]      r_res_flags, w_res_flags_d;

  assign w_wa    = r_wptr[AW-1:0];
  assign w_ra    = r_rptr[AW-1:0];
  assign w_empty = (r_wptr == r_rptr);
  // Extra pointer bit differs only when the write side has lapped the read side.
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (w_wa == w_ra);
  assign w_push  = bus.req_valid && !w_full;
  // A launch needs an empty result slot, so back-pressure stalls issue instead of dropping.
  assign w_pop   = (r_state == StIdle) && !w_empty && !r_res_valid;

  // Request storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[w_wa]   <= bus.req_a;
      r_mem_b[w_wa]   <= bus.req_b;
      r_mem_rm[w_wa]  <= bus.req_rm;
      r_mem_tag[w_wa] <= bus.req_tag;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Next-state and registered-output logic of the issue FSM.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_div_rst_d   = 1'b0;
    w_div_ld_d    = 1'b0;
    w_div_a_d     = r_div_a;
    w_div_b_d     = r_div_b;
    w_div_rm_d    = r_div_rm;
    w_tag_d       = r_tag;
    w_res_valid_d = r_res_valid;
    w_res_o_d     = r_res_o;
    w_res_tag_d   = r_res_tag;
    w_res_flags_d = r_res_flags;
    if (r_res_valid && bus.res_ready) w_res_valid_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_pop) begin
          w_div_a_d  = r_mem_a[w_ra];
          w_div_b_d  = r_mem_b[w_ra];
          w_div_rm_d = r_mem_rm[w_ra];
          w_tag_d    = r_mem_tag[w_ra];
          w_div_ld_d = 1'b1;
          w_state_d  = StLaunch;
        end
      end
      StLaunch: begin
        w_cnt_d   = '0;
        w_state_d = StMask;
      end
      StMask: begin
        // div_done still reflects the previous operation here.
        if (r_cnt == MaskLast) begin
          w_cnt_d   = '0;
          w_state_d = StWait;
        end else begin
          w_cnt_d = r_cnt + 10'd1;
        end
      end
      StWait: begin
        if (div_done) begin
          w_res_valid_d = 1'b1;
          w_res_o_d     = div_o;
          w_res_tag_d   = r_tag;
          w_res_flags_d = {1'b0, div_inf, div_ovf, div_unf};
          w_state_d     = StIdle;
        end else if (r_cnt == TimeoutLast) begin
          w_res_valid_d = 1'b1;
          w_res_o_d     = QNaN;
          w_res_tag_d   = r_tag;
          w_res_flags_d = 4'b1000;
          w_div_rst_d   = 1'b1;
          w_state_d     = StIdle;
        end else begin
          w_cnt_d = r_cnt + 10'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // FSM state and registered outputs; div_rst leaves reset high for one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_div_rst   <= 1'b1;
      r_div_ld    <= 1'b0;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_div_rm    <= '0;
      r_tag       <= '0;
      r_res_valid <= 1'b0;
      r_res_o     <= '0;
      r_res_tag   <= '0;
      r_res_flags <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_div_rst   <= w_div_rst_d;
      r_div_ld    <= w_div_ld_d;
      r_div_a     <= w_div_a_d;
      r_div_b     <= w_div_b_d;
      r_div_rm    <= w_div_rm_d;
      r_tag       <= w_tag_d;
      r_res_valid <= w_res_valid_d;
      r_res_o     <= w_res_o_d;
      r_res_tag   <= w_res_tag_d;
      r_res_flags <= w_res_flags_d;
    end
  end

  assign bus.req_ready = !w_full;
  assign bus.res_valid = r_res_valid;
  assign bus.res_o     = r_res_o;
  assign bus.res_tag   = r_res_tag;
  assign bus.res_flags = r_res_flags;
  assign div_rst       = r_div_rst;
  assign div_ld        = r_div_ld;
  assign div_a         = r_div_a;
  assign div_b         = r_div_b;
  assign div_rm        = r_div_rm;
  assign busy          = !w_empty || (r_state != StIdle) || r_res_valid;
endmodule

// File: tb/tb_fp_div48_seq.sv
// Directed bench for fp_div48_seq with a behavioural divider model and in-order scoreboard.
`timescale 1ns/1ps
module tb_fp_div48_seq;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned TAGW      = 4;
  localparam int unsigned DONE_MASK = 4;
  localparam int unsigned TIMEOUT   = 255;
  localparam int          LAT       = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        div_rst, div_ld, busy;
  logic [47:0] div_a, div_b;
  logic [2:0]  div_rm;
  logic [47:0] div_o = '0;
  logic        div_done = 1'b0, div_inf = 1'b0, div_ovf = 1'b0, div_unf = 1'b0;

  fp_div48_seq_if #(.TAGW(TAGW)) u_if ();

  fp_div48_seq #(
    .DEPTH(DEPTH), .TAGW(TAGW), .DONE_MASK(DONE_MASK), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(u_if),
    .div_rst(div_rst), .div_ld(div_ld), .div_a(div_a), .div_b(div_b), .div_rm(div_rm),
    .div_o(div_o), .div_done(div_done), .div_inf(div_inf), .div_ovf(div_ovf),
    .div_unf(div_unf), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // Hand-computed FP48 quotients (double-style 1/11/36 layout) and {inf,ovf,unf}.
  logic [47:0] vec_a [7] = '{48'h4018_0000_0000, 48'h3FF0_0000_0000, 48'h4020_0000_0000,
                             48'h4022_0000_0000, 48'h4024_0000_0000, 48'hC018_0000_0000,
                             48'h3FF0_0000_0000};
  logic [47:0] vec_b [7] = '{48'h4000_0000_0000, 48'h4000_0000_0000, 48'h4010_0000_0000,
                             48'h4008_0000_0000, 48'h4000_0000_0000, 48'h4000_0000_0000,
                             48'h0000_0000_0000};
  logic [47:0] vec_q [7] = '{48'h4008_0000_0000, 48'h3FE0_0000_0000, 48'h4000_0000_0000,
                             48'h4008_0000_0000, 48'h4014_0000_0000, 48'hC008_0000_0000,
                             48'h7FF0_0000_0000};
  logic [2:0]  vec_f [7] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100};

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [47:0]     res;
    logic [3:0]      flags;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_ld     = 0;
  int   n_res    = 0;
  int   mode     = 0;  // 0 normal, 1 stale-done pattern, 2 done stuck low

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [50:0] lookup(input logic [47:0] a, input logic [47:0] b);
    for (int i = 0; i < 7; i++)
      if (vec_a[i] == a && vec_b[i] == b) return {vec_f[i], vec_q[i]};
    return {3'b000, 48'hBAD0_BAD0_BAD0};
  endfunction

  // Divider model; result follows the live operands so mid-operation changes show up.
  initial begin
    int m_cnt = 1000;
    forever begin
      @(posedge clk); #1;
      if (div_ld) m_cnt = 0;
      else if (m_cnt < 100000) m_cnt++;
      if (div_rst) div_done = 1'b0;
      else begin
        case (mode)
          0: if (m_cnt >= LAT) div_done = 1'b1; else if (m_cnt >= 2) div_done = 1'b0;
          1: div_done = (m_cnt <= DONE_MASK) || (m_cnt > DONE_MASK + 20);
          default: div_done = 1'b0;
        endcase
      end
      if (div_done) {div_inf, div_ovf, div_unf, div_o} = lookup(div_a, div_b);
      else {div_inf, div_ovf, div_unf, div_o} = '0;
    end
  end

  // Monitor: load-pulse count/width and in-order result scoreboard.
  initial begin
    bit ld_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (div_ld) begin
        n_ld++;
        check("ld_pulse_width", 64'(ld_prev), 64'd0);
      end
      ld_prev = div_ld;
      if (u_if.res_valid && u_if.res_ready) begin
        n_res++;
        if (exp_q.size() == 0) check("res_unexpected", 64'(exp_q.size()), 64'd1);
        else begin
          e = exp_q.pop_front();
          check("res_tag", 64'(u_if.res_tag), 64'(e.tag));
          check("res_o", 64'(u_if.res_o), 64'(e.res));
          check("res_flags", 64'(u_if.res_flags), 64'(e.flags));
        end
      end
    end
  end

  task automatic add_exp(input int idx, input logic [TAGW-1:0] tag);
    exp_t e;
    e.tag   = tag;
    e.res   = vec_q[idx];
    e.flags = {1'b0, vec_f[idx]};
    exp_q.push_back(e);
  endtask

  task automatic push(input int idx, input logic [2:0] rm, input logic [TAGW-1:0] tag);
    logic rdy;
    bit   ok = 1'b0;
    @(negedge clk);
    u_if.req_valid = 1'b1;
    u_if.req_a     = vec_a[idx];
    u_if.req_b     = vec_b[idx];
    u_if.req_rm    = rm;
    u_if.req_tag   = tag;
    for (int i = 0; i < 3000; i++) begin
      rdy = u_if.req_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 u_if.req_valid = 1'b0;
    check("push_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_ld(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (div_ld) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", 64'(ok), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n0, nr0, k, bad;
    u_if.req_valid = 1'b0;
    u_if.req_a     = '0;
    u_if.req_b     = '0;
    u_if.req_rm    = '0;
    u_if.req_tag   = '0;
    u_if.res_ready = 1'b1;

    // Reset values and div_rst release behaviour.
    #1 rst_n = 1'b0;
    #20;
    check("rst_res_valid", 64'(u_if.res_valid), 64'd0);
    check("rst_res_o", 64'(u_if.res_o), 64'd0);
    check("rst_div_ld", 64'(div_ld), 64'd0);
    check("rst_div_a", 64'(div_a), 64'd0);
    check("rst_div_rst", 64'(div_rst), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(u_if.req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_div_rst_hi", 64'(div_rst), 64'd1);
    @(posedge clk); #1;
    check("rel_div_rst_lo", 64'(div_rst), 64'd0);

    // Single request: 6.0 / 2.0, tag 5, launch latency and result latency.
    n0 = n_ld;
    add_exp(0, 4'd5);
    push(0, 3'd0, 4'd5);
    check("t1_ld_early", 64'(div_ld), 64'd0);
    @(posedge clk); #1;
    check("t1_ld", 64'(div_ld), 64'd1);
    check("t1_div_a", 64'(div_a), 64'(vec_a[0]));
    check("t1_div_b", 64'(div_b), 64'(vec_b[0]));
    check("t1_div_rm", 64'(div_rm), 64'd0);
    k = 0;
    for (int i = 0; i < 50; i++) begin
      if (u_if.res_valid) break;
      @(posedge clk); #1;
      k++;
    end
    check("t1_res_latency", 64'(k), 64'(LAT + 1));
    wait_idle(50);
    // Divide by zero reports the infinity flag.
    add_exp(6, 4'd6);
    push(6, 3'd5, 4'd6);
    @(posedge clk); #1;
    check("t1b_div_rm", 64'(div_rm), 64'd5);
    check("t1b_div_b", 64'(div_b), 64'd0);
    wait_idle(50);
    check("t1_ld_count", 64'(n_ld - n0), 64'd2);

    // Back-to-back: FIFO fills behind a busy divider, results stay in order.
    n0 = n_ld;
    nr0 = n_res;
    for (int t = 0; t < 6; t++) add_exp(t, TAGW'(t));
    for (int t = 0; t < 5; t++) push(t, 3'd0, TAGW'(t));
    @(negedge clk);
    check("t2_req_ready_full", 64'(u_if.req_ready), 64'd0);
    push(5, 3'd0, 4'd5);
    wait_idle(400);
    check("t2_ld_count", 64'(n_ld - n0), 64'd6);
    check("t2_res_count", 64'(n_res - nr0), 64'd6);

    // Stale done held through the mask window, then a 20-cycle gap before real done.
    mode = 1;
    add_exp(1, 4'd1);
    push(1, 3'd0, 4'd1);
    wait_ld("t3_ld_seen");
    k = 0;
    for (int i = 0; i < 100; i++) begin
      if (u_if.res_valid) break;
      @(posedge clk); #1;
      k++;
    end
    check("t3_res_latency", 64'(k), 64'(DONE_MASK + 22));
    wait_idle(50);
    mode = 0;

    // Back-pressure: result held, no further launch until the slot drains.
    u_if.res_ready = 1'b0;
    add_exp(2, 4'd2);
    add_exp(3, 4'd3);
    push(2, 3'd0, 4'd2);
    push(3, 3'd0, 4'd3);
    for (int i = 0; i < 100; i++) begin
      if (u_if.res_valid) break;
      @(posedge clk); #1;
    end
    n0 = n_ld;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!u_if.res_valid || u_if.res_o !== vec_q[2] || u_if.res_tag !== 4'd2) bad++;
    end
    check("t4_held_stable", 64'(bad), 64'd0);
    check("t4_no_launch", 64'(n_ld - n0), 64'd0);
    check("t4_busy", 64'(busy), 64'd1);
    u_if.res_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      k++;
      if (div_ld) break;
    end
    check("t4_relaunch_cycles", 64'(k), 64'd2);
    wait_idle(100);

    // Watchdog: done never rises, qNaN with timeout flag, then the queue resumes.
    mode = 2;
    exp_q.push_back('{tag: 4'd4, res: 48'h7FF8_0000_0000, flags: 4'b1000});
    add_exp(5, 4'd5);
    push(4, 3'd0, 4'd4);
    push(5, 3'd0, 4'd5);
    wait_ld("t5_ld_seen");
    k = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      k++;
      if (div_rst) break;
    end
    check("t5_timeout_cycles", 64'(k), 64'(DONE_MASK + TIMEOUT + 1));
    check("t5_res_valid", 64'(u_if.res_valid), 64'd1);
    mode = 0;
    @(posedge clk); #1;
    check("t5_div_rst_pulse", 64'(div_rst), 64'd0);
    wait_idle(100);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-divide with three requests still queued.
    mode = 2;
    n0 = n_ld;
    for (int t = 0; t < 4; t++) push(t, 3'd0, TAGW'(t));
    repeat (12) @(posedge clk);
    #1 check("t6_busy_before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_res_valid", 64'(u_if.res_valid), 64'd0);
    check("t6_div_ld", 64'(div_ld), 64'd0);
    check("t6_div_a", 64'(div_a), 64'd0);
    check("t6_div_rm", 64'(div_rm), 64'd0);
    check("t6_div_rst", 64'(div_rst), 64'd1);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_req_ready", 64'(u_if.req_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("t6_rel_div_rst_hi", 64'(div_rst), 64'd1);
    @(posedge clk); #1;
    check("t6_rel_div_rst_lo", 64'(div_rst), 64'd0);
    mode = 0;
    repeat (300) @(posedge clk);
    #1;
    check("t6_no_relaunch", 64'(n_ld - n0), 64'd1);
    check("t6_idle_after", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
